// File: rtl/reg_file_pkg.sv
// Shared types and sizes for the 16x16 register file.
package reg_file_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0]   reg_data_t;
  typedef logic [ADDR_W-1:0]   reg_addr_t;
  // One bit per register row, used for one-hot word selects.
  typedef logic [NUM_REGS-1:0] reg_sel_t;

endpackage

// File: rtl/reg_file_dec_4_16.sv
// 4->16 one-hot decoder with enable; output is all-zero when disabled.
module reg_file_dec_4_16
  import reg_file_pkg::*;
(
  input  logic      i_en,
  input  reg_addr_t i_addr,
  output reg_sel_t  o_sel
);

  // Set exactly the bit addressed by i_addr when enabled.
  always_comb begin
    o_sel = '0;
    if (i_en) begin
      o_sel[i_addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_16x16.sv
// 16-entry x 16-bit register file: two combinational read ports, one
// synchronous write port, same-cycle write-to-read bypass.
// Build option: define REGFILE_R0_ZERO_EN to hardwire register 0 to zero
// (writes to it discarded, reads return zero, no bypass for index 0).
module reg_file_16x16
  import reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t srcReg_1,
  input  reg_addr_t srcReg_2,
  input  reg_addr_t dstReg,
  input  logic      writeReg,
  input  reg_data_t dstData,
  output reg_data_t srcData_1,
  output reg_data_t srcData_2
);

`ifdef REGFILE_R0_ZERO_EN
  // Row 0 is removed from every select so it can never be written or read.
  localparam reg_sel_t RowMask = {{(NUM_REGS-1){1'b1}}, 1'b0};
`else
  localparam reg_sel_t RowMask = '1;
`endif

  reg_data_t r_regs [NUM_REGS];

  reg_sel_t  w_rd1_dec;
  reg_sel_t  w_rd2_dec;
  reg_sel_t  w_wr_dec;
  reg_sel_t  w_rd1_sel;
  reg_sel_t  w_rd2_sel;
  reg_sel_t  w_wr_sel;
  reg_data_t w_mux1;
  reg_data_t w_mux2;
  logic      w_byp1;
  logic      w_byp2;

  reg_file_dec_4_16 u_dec_rd1 (
    .i_en   (1'b1),
    .i_addr (srcReg_1),
    .o_sel  (w_rd1_dec)
  );

  reg_file_dec_4_16 u_dec_rd2 (
    .i_en   (1'b1),
    .i_addr (srcReg_2),
    .o_sel  (w_rd2_dec)
  );

  reg_file_dec_4_16 u_dec_wr (
    .i_en   (writeReg),
    .i_addr (dstReg),
    .o_sel  (w_wr_dec)
  );

  assign w_rd1_sel = w_rd1_dec & RowMask;
  assign w_rd2_sel = w_rd2_dec & RowMask;
  assign w_wr_sel  = w_wr_dec & RowMask;

  // Storage: async clear of every row; otherwise write the selected row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_wr_sel[k]) begin
          r_regs[k] <= dstData;
        end
      end
    end
  end

  // AND-OR row mux for both read ports.
  always_comb begin
    w_mux1 = '0;
    w_mux2 = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_mux1 = w_mux1 | ({DATA_W{w_rd1_sel[k]}} & r_regs[k]);
      w_mux2 = w_mux2 | ({DATA_W{w_rd2_sel[k]}} & r_regs[k]);
    end
  end

  // A port bypasses when its row is the one being written this cycle.
  assign w_byp1 = |(w_rd1_sel & w_wr_sel);
  assign w_byp2 = |(w_rd2_sel & w_wr_sel);

  // Reset forces zero even though a pending write would otherwise bypass.
  assign srcData_1 = !rst ? '0 : (w_byp1 ? dstData : w_mux1);
  assign srcData_2 = !rst ? '0 : (w_byp2 ? dstData : w_mux2);

endmodule

// File: tb/tb_reg_file_16x16.sv
// Self-checking bench for reg_file_16x16: directed vector table, reset and
// decoder sequences, then random traffic against an array-based model.
module tb_reg_file_16x16;
  import reg_file_pkg::*;

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  logic      clk = 1'b0;
  logic      rst = 1'b0;
  reg_addr_t s1, s2, dst;
  logic      we;
  reg_data_t din;
  reg_data_t q1, q2;

  int n_checks = 0;
  int n_errors = 0;

  reg_data_t mdl [NUM_REGS];

  typedef struct {
    logic      we;
    reg_addr_t dst;
    reg_data_t din;
    reg_addr_t s1;
    reg_addr_t s2;
    reg_data_t e1;
    reg_data_t e2;
    string     name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  reg_file_16x16 u_dut (
    .clk       (clk),
    .rst       (rst),
    .srcReg_1  (s1),
    .srcReg_2  (s2),
    .dstReg    (dst),
    .writeReg  (we),
    .dstData   (din),
    .srcData_1 (q1),
    .srcData_2 (q2)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need finish");
    $fatal(1);
  end

  // Expected value of a stored register given the R0 option.
  function automatic reg_data_t z(int idx, reg_data_t val);
    if (R0Z && idx == 0) return '0;
    return val;
  endfunction

  // Reference read: reset forces zero, bypass wins, else stored value.
  function automatic reg_data_t ref_read(reg_addr_t a);
    if (!rst) return '0;
    if (R0Z && a == 0) return '0;
    if (we && dst == a) return din;
    return mdl[a];
  endfunction

  function automatic vec_t mk(logic w, int d, reg_data_t dd, int a1, int a2,
                              reg_data_t x1, reg_data_t x2, string nm);
    vec_t v;
    v.we = w; v.dst = reg_addr_t'(d); v.din = dd;
    v.s1 = reg_addr_t'(a1); v.s2 = reg_addr_t'(a2);
    v.e1 = x1; v.e2 = x2; v.name = nm;
    return v;
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, need %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rising edge: the model takes the write the DUT should take.
  task automatic tick();
    @(posedge clk);
    if (rst && we && !(R0Z && dst == 0)) mdl[dst] = din;
  endtask

  task automatic clear_model();
    for (int k = 0; k < NUM_REGS; k++) mdl[k] = '0;
  endtask

  initial begin
    clear_model();
    // In reset with a would-be bypass present: outputs must still be zero.
    we = 1'b1; dst = 4'd5; din = 16'hABCD; s1 = 4'd5; s2 = 4'd5;
    #2;
    check("reset_q1", q1, 16'h0000);
    check("reset_q2", q2, 16'h0000);
    tick();
    @(negedge clk);
    rst = 1'b1; we = 1'b0;
    #2;
    check("release_q1", q1, 16'h0000);
    tick();

    // Async reset between edges clears stored data immediately.
    @(negedge clk);
    we = 1'b1; dst = 4'd5; din = 16'hBEEF; s1 = 4'd5; s2 = 4'd0;
    #2;
    check("beef_bypass", q1, 16'hBEEF);
    tick();
    @(negedge clk);
    we = 1'b0;
    #1;
    check("beef_stored", q1, 16'hBEEF);
    rst = 1'b0;
    #1;
    check("rst_async", q1, 16'h0000);
    clear_model();
    #1;
    rst = 1'b1;
    #1;
    check("rst_released", q1, 16'h0000);
    tick();
    for (int k = 0; k < NUM_REGS; k++) begin
      @(negedge clk);
      s1 = reg_addr_t'(k); s2 = reg_addr_t'(15 - k);
      #2;
      check("post_rst_q1", q1, 16'h0000);
      check("post_rst_q2", q2, 16'h0000);
      tick();
    end

    // Reset held across an edge overrides an in-flight write.
    @(negedge clk);
    we = 1'b1; dst = 4'd9; din = 16'h7777; rst = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1; we = 1'b0; s1 = 4'd9;
    #2;
    check("rst_kills_write", q1, 16'h0000);
    tick();

    // Directed vector table.
    for (int k = 0; k < NUM_REGS; k++)
      vecs.push_back(mk(1'b1, k, reg_data_t'(16'h1111 * k), k, k,
                        z(k, reg_data_t'(16'h1111 * k)), z(k, reg_data_t'(16'h1111 * k)),
                        "wr_bypass"));
    for (int k = 0; k < NUM_REGS; k++)
      vecs.push_back(mk(1'b0, k, 16'hFFFF, k, 15 - k,
                        z(k, reg_data_t'(16'h1111 * k)),
                        z(15 - k, reg_data_t'(16'h1111 * (15 - k))), "readback"));
    vecs.push_back(mk(1'b1, 3, 16'h00AA, 3, 3, 16'h00AA, 16'h00AA, "wdis_set"));
    vecs.push_back(mk(1'b0, 3, 16'h5555, 3, 3, 16'h00AA, 16'h00AA, "wdis_drive"));
    vecs.push_back(mk(1'b0, 0, 16'h0000, 3, 3, 16'h00AA, 16'h00AA, "wdis_hold"));
    vecs.push_back(mk(1'b1, 7, 16'h1234, 7, 7, 16'h1234, 16'h1234, "byp_set"));
    vecs.push_back(mk(1'b1, 7, 16'hCAFE, 7, 7, 16'hCAFE, 16'hCAFE, "byp_both"));
    vecs.push_back(mk(1'b0, 0, 16'h0000, 7, 7, 16'hCAFE, 16'hCAFE, "byp_after"));
    vecs.push_back(mk(1'b1, 7, 16'hCAFE, 6, 7, 16'h6666, 16'hCAFE, "byp_other_row"));

    foreach (vecs[i]) begin
      @(negedge clk);
      we = vecs[i].we; dst = vecs[i].dst; din = vecs[i].din;
      s1 = vecs[i].s1; s2 = vecs[i].s2;
      #2;
      check({vecs[i].name, "_q1"}, q1, vecs[i].e1);
      check({vecs[i].name, "_q2"}, q2, vecs[i].e2);
      tick();
    end

    // Decoder sweep: one-hot read select and gated write select.
    for (int k = 0; k < NUM_REGS; k++) begin
      @(negedge clk);
      we = 1'b0; s1 = reg_addr_t'(k); dst = reg_addr_t'(k);
      din = reg_data_t'($urandom);
      #1;
      check("dec_rd", u_dut.w_rd1_dec, 16'(1) << k);
      check("dec_wr_off", u_dut.w_wr_dec, 16'h0000);
      we = 1'b1;
      #1;
      check("dec_wr_on", u_dut.w_wr_dec, 16'(1) << k);
      check("dec_q1", q1, ref_read(s1));
      tick();
    end

    // Random traffic against the model, with one mid-cycle reset.
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      we  = 1'($urandom_range(0, 1));
      dst = reg_addr_t'($urandom);
      din = reg_data_t'($urandom);
      s1  = reg_addr_t'($urandom);
      s2  = ($urandom_range(0, 3) == 0) ? dst : reg_addr_t'($urandom);
      #2;
      check("rand_q1", q1, ref_read(s1));
      check("rand_q2", q2, ref_read(s2));
      if (i == 250) begin
        #1;
        rst = 1'b0;
        #1;
        check("rand_rst_q1", q1, 16'h0000);
        check("rand_rst_q2", q2, 16'h0000);
        clear_model();
        rst = 1'b1;
      end
      tick();
    end

    @(negedge clk);
    we = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_16x16.md
Name: reg_file_16x16

Overview:
- 16-entry x 16-bit register file: two combinational read ports, one synchronous write port.
- Same-cycle write-to-read bypass.
- Feeds the CPU decode/execute stage: srcReg_1/srcReg_2 come from instruction source fields, dstReg/dstData from writeback.
- Storage is conceptually a 16x16 array of bit cells; word select uses a one-hot decode of each read address.

Parameters:
- DATA_W, 16, width of each register and of all data ports.
- ADDR_W, 4, register address width; entry count NUM_REGS = 2**ADDR_W = 16.

Ports:
- clk  input  1  single clock; all storage updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low: 0 = in reset.
- srcReg_1  input  ADDR_W  read port 1 register index.
- srcReg_2  input  ADDR_W  read port 2 register index.
- dstReg  input  ADDR_W  write port register index.
- writeReg  input  1  write enable, active high.
- dstData  input  DATA_W  write data.
- srcData_1  output  DATA_W  read port 1 data.
- srcData_2  output  DATA_W  read port 2 data.

Behaviour:
- Reset: rst falling clears all 16 registers to 16'h0000 immediately, with no clock needed.
  - While rst=0, writes are ignored and srcData_1 = srcData_2 = 16'h0000.
  - Release (rst 0->1) is clean; the first write can land on the next rising edge.
- Write: on posedge clk with rst=1 and writeReg=1, reg[dstReg] <= dstData.
  - writeReg=0: no register changes.
  - Only one entry is written per cycle.
- Read: srcData_N = reg[srcReg_N], combinational, 0-cycle latency. Both ports are always driven; no tristate/high-Z outputs.
- Bypass: if writeReg=1 and dstReg == srcReg_N, srcData_N = dstData in the same cycle, before the edge. It applies independently to each port, so both ports can bypass simultaneously when srcReg_1 == srcReg_2 == dstReg.
- After the write edge, the stored value equals the bypassed value, so the output does not glitch across the edge when inputs are held.
- Address decode: each read address is decoded 4->16 one-hot (bit k set iff address == k). The one-hot word selects the row (AND-OR mux).
- Write decode: one-hot, gated by writeReg; all-zero when writeReg=0.
- All 16 registers, including reg 0, are general-purpose unless R0_ZERO_EN is defined.
- Reset mid-operation asserts asynchronously, overrides any in-flight write, and wipes all contents.

Optional Feature:
- Macro REGFILE_R0_ZERO_EN.
- Defined: reg 0 is hardwired to 16'h0000.
  - Writes to dstReg=0 are discarded.
  - Reads of index 0 return 0.
  - No bypass for index 0.
- Undefined (default): reg 0 behaves like every other register.

Decomposition:
- Shared package reg_file_pkg holds:
  - localparams DATA_W=16, ADDR_W=4, NUM_REGS=16;
  - typedef reg_data_t (logic [DATA_W-1:0]);
  - typedef reg_addr_t (logic [ADDR_W-1:0]).
- One sub-module, reg_file_dec_4_16: combinational 4->16 one-hot decoder with an enable input.
  - Instantiated three times: read 1 and read 2 with enable tied high; write with enable = writeReg.
- Storage array, bypass and output muxing stay in the top.

Test Plan:
- Reset: write 16'hBEEF to reg 5, pulse rst=0 between edges -> srcData_1 = 0 immediately. After release, reading all 16 indices returns 16'h0000.
- Write/read-back: write reg k = 16'h1111*k for k=0..15 (writeReg=1). Then set writeReg=0 and sweep srcReg_1 = k, srcReg_2 = 15-k -> both ports return the matching values (reg 0 returns 0 under R0_ZERO_EN).
- Write disable: reg 3 = 16'h00AA; drive writeReg=0, dstReg=3, dstData=16'h5555 for one edge -> reg 3 still reads 16'h00AA.
- Bypass: reg 7 = 16'h1234; drive writeReg=1, dstReg=7, dstData=16'hCAFE, srcReg_1=srcReg_2=7.
  - Before the edge: both ports = 16'hCAFE.
  - After the edge, with writeReg=0: still 16'hCAFE.
  - With srcReg_1 = 6 instead, port 1 shows reg 6's stored value, not 16'hCAFE.
- Decoder: sweep the read address 0..15 -> the one-hot selects exactly row k.
  - Write decoder output = 1<<dstReg when writeReg=1, 16'h0000 when writeReg=0.
- Random: 500 cycles of random dstReg/dstData/writeReg/srcReg_1/srcReg_2 checked against a 16-entry reference model including bypass -> zero mismatches.
